// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and lookup.
package ssd_pkg;

    // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active high.
    localparam logic [6:0] SSD_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        return SSD_HEX[nib];
    endfunction

endpackage

// File: rtl/ssd_lz_mask.sv
// Leading-zero blank mask: bit i set when nibbles DIGITS-1..i are all zero (digit 0 never blanks).
module ssd_lz_mask #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] nib_i,
    output logic [DIGITS-1:0]   mask_o
);

    logic all_zero;

    always_comb begin
        all_zero = 1'b1;
        mask_o   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero  = all_zero & (nib_i[4*i +: 4] == 4'h0);
            mask_o[i] = all_zero;
        end
    end

endmodule

// File: rtl/ssd_scan.sv
// N-digit multiplexed seven-segment driver with frame-coherent shadows,
// leading-zero blanking, PWM brightness and a one-cycle anti-ghosting guard per slot.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SCAN_W        = 10,
    parameter int BRIGHT_W      = 3,
    parameter bit AN_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W:0]     brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? '1 : '0;

    logic [SCAN_W-1:0]   slot_cnt_q;
    logic [DW-1:0]       dig_idx_q;
    logic                init_q;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic                blank_q;
    logic [BRIGHT_W:0]   bright_q;

    logic [6:0]          seg_q, seg_d;
    logic                dp_o_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fs_q, fs_d;

    logic                slot_last, dig_last, frame_load;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nib;
    logic                pwm_on;

    ssd_lz_mask #(.DIGITS(DIGITS)) u_lz (
        .nib_i  (value_q),
        .mask_o (lz_mask)
    );

    assign slot_last  = &slot_cnt_q;
    assign dig_last   = (dig_idx_q == DW'(DIGITS - 1));
    // Shadows refresh on the edge entering digit 0 slot 0, or right after reset.
    assign frame_load = init_q | (slot_last & dig_last);

    always_comb begin
        nib    = value_q[4*int'(dig_idx_q) +: 4];
        seg_d  = (blank_q && lz_mask[dig_idx_q]) ? 7'h00 : seg7(nib);
        dp_d   = dp_q[dig_idx_q];
        pwm_on = ({1'b0, slot_cnt_q[SCAN_W-1 -: BRIGHT_W]} < bright_q);
        an_d   = '0;
        // Slot 0 is always dark so the previous digit's segments never ghost.
        if (pwm_on && (slot_cnt_q != '0))
            an_d[dig_idx_q] = 1'b1;
        if (AN_ACTIVE_LOW)
            an_d = ~an_d;
        fs_d   = (slot_cnt_q == '0) && (dig_idx_q == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= '0;
            init_q     <= 1'b1;
            value_q    <= '0;
            dp_q       <= '0;
            blank_q    <= 1'b0;
            bright_q   <= '0;
            seg_q      <= '0;
            dp_o_q     <= 1'b0;
            an_q       <= AN_IDLE;
            fs_q       <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
            if (slot_last)
                dig_idx_q <= dig_last ? '0 : dig_idx_q + 1'b1;
            init_q <= 1'b0;
            if (frame_load) begin
                value_q  <= value;
                dp_q     <= dp_in;
                blank_q  <= blank_lz;
                bright_q <= brightness;
            end
            seg_q  <= seg_d;
            dp_o_q <= dp_d;
            an_q   <= an_d;
            fs_q   <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_o_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan: 4 digits, 16-cycle slots, 3-bit brightness.
module tb_ssd_scan;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'd8;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    ssd_scan #(.DIGITS(4), .SCAN_W(4), .BRIGHT_W(3), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .value       (value),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic             blank;
        logic [3:0]       bright;
        logic [3:0][6:0]  seg;   // expected glyph for digits 3..0
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset with inputs already applied; returns just after the first live edge.
    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int s, d;
        logic [3:0] exp_an;
        value      = v.value;
        dp_in      = v.dp;
        blank_lz   = v.blank;
        brightness = v.bright;
        do_reset();
        chk($sformatf("v%0d fs0", idx), frame_start, 1);
        chk($sformatf("v%0d an0", idx), an, 0);
        for (int c = 1; c <= 64; c++) begin
            step();
            s = c % 16;
            d = (c / 16) % 4;
            exp_an = (s != 0 && (s >> 1) < int'(v.bright)) ? 4'(1 << d) : 4'h0;
            chk($sformatf("v%0d an c=%0d", idx, c), an, exp_an);
            chk($sformatf("v%0d fs c=%0d", idx, c), frame_start, (c % 64 == 0) ? 1 : 0);
            if (s == 8 && v.bright != 0) begin
                chk($sformatf("v%0d seg d%0d", idx, d), seg, v.seg[d]);
                chk($sformatf("v%0d dp d%0d", idx, d), dp, v.dp[d]);
            end
        end
    endtask

    initial begin
        vt[0] = '{16'hA3F0, 4'b0000, 1'b0, 4'd8,  {7'h77, 7'h79, 7'h47, 7'h7E}};
        vt[1] = '{16'h0050, 4'b1100, 1'b1, 4'd8,  {7'h00, 7'h00, 7'h5B, 7'h7E}};
        vt[2] = '{16'h0000, 4'b0001, 1'b1, 4'd8,  {7'h00, 7'h00, 7'h00, 7'h7E}};
        vt[3] = '{16'h0000, 4'b0000, 1'b0, 4'd2,  {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vt[4] = '{16'h1234, 4'b0000, 1'b0, 4'd0,  {7'h30, 7'h6D, 7'h79, 7'h33}};
        vt[5] = '{16'hBEEF, 4'b1010, 1'b0, 4'd15, {7'h1F, 7'h4F, 7'h4F, 7'h47}};
        vt[6] = '{16'h0708, 4'b0000, 1'b1, 4'd8,  {7'h00, 7'h70, 7'h7E, 7'h7F}};

        // Reset held low: everything dark.
        #1 resetn = 1'b0;
        repeat (3) step();
        chk("rst an", an, 0);
        chk("rst seg", seg, 0);
        chk("rst dp", dp, 0);
        chk("rst fs", frame_start, 0);

        for (int i = 0; i < 7; i++)
            run_frame(vt[i], i);

        // Tearing: change value mid-frame, old frame must finish intact.
        value = 16'h1111; dp_in = '0; blank_lz = 1'b0; brightness = 4'd8;
        do_reset();
        for (int c = 1; c <= 120; c++) begin
            step();
            if (c == 36) value = 16'h2222;
            if (c == 40) chk("tear d2 old", seg, 7'h30);
            if (c == 56) chk("tear d3 old", seg, 7'h30);
            if (c == 64) chk("tear fs", frame_start, 1);
            if (c == 72 || c == 88 || c == 104 || c == 120)
                chk($sformatf("tear new c=%0d", c), seg, 7'h6D);
        end

        // Asynchronous reset in the middle of digit 2.
        value = 16'h4444;
        do_reset();
        for (int c = 1; c <= 40; c++) step();
        chk("pre-ar an", an, 4'b0100);
        #2;
        value  = 16'h0009;
        resetn = 1'b0;
        #1;
        chk("ar an", an, 0);
        chk("ar seg", seg, 0);
        chk("ar fs", frame_start, 0);
        step();
        resetn = 1'b1;
        step();
        chk("ar resume fs", frame_start, 1);
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 8) begin
                chk("ar resume seg d0", seg, 7'h73);
                chk("ar resume an d0", an, 4'b0001);
            end
            if (c == 24) chk("ar resume seg d1", seg, 7'h7E);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
